// File: rtl/mips_vn_memory.sv
// Unified instruction/data memory for the von Neumann multicycle MIPS core.
// One port serves both fetches and loads/stores with one-cycle synchronous reads.
// The I/O page holds LEDs, a free-running cycle counter and a 4-deep TX byte FIFO.
module mips_vn_memory #(
  parameter int    N          = 32,
  parameter int    DEPTH_LOG2 = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_wr_data,
  input  logic         mem_wr_ena,
  output logic [N-1:0] mem_rd_data,
  output logic [N-1:0] leds,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         access_fault
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [5:0] OFF_LEDS   = 6'd0;
  localparam logic [5:0] OFF_CYCLE  = 6'd1;
  localparam logic [5:0] OFF_TX     = 6'd2;
  localparam logic [5:0] OFF_STATUS = 6'd3;

  logic [N-1:0]          ram [DEPTH];
  logic [N-1:0]          ram_q;
  logic [N-1:0]          io_q;
  logic                  sel_ram_q;
  logic [N-1:0]          cycle_count;
  logic [7:0]            fifo_mem [4];
  logic [1:0]            rd_ptr;
  logic [1:0]            wr_ptr;
  logic [2:0]            count;
  logic                  overflow;

  logic                  is_io;
  logic                  in_range;
  logic                  aligned;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [5:0]            io_off;
  logic                  ram_wr;
  logic                  io_wr;
  logic                  io_wr_known;
  logic                  fault_set;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  full;
  logic [N-1:0]          status_val;
  logic [N-1:0]          io_rd_val;

  // Address decode: bit 31 splits RAM from the I/O page
  assign is_io    = mem_addr[N-1];
  assign in_range = (mem_addr[N-2:DEPTH_LOG2+2] == '0);
  assign aligned  = (mem_addr[1:0] == 2'b00);
  assign word_idx = mem_addr[DEPTH_LOG2+1:2];
  assign io_off   = mem_addr[7:2];

  // A write coincident with reset is ignored, so every strobe is qualified by !rst
  assign ram_wr      = mem_wr_ena && !rst && !is_io && in_range && aligned;
  assign io_wr       = mem_wr_ena && !rst && is_io && aligned;
  assign io_wr_known = io_wr && (io_off <= OFF_STATUS);
  assign fault_set   = mem_wr_ena && !rst && !(ram_wr || io_wr_known);

  assign full     = (count == 3'd4);
  assign tx_valid = (count != 3'd0);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;
  assign push     = io_wr && (io_off == OFF_TX);
  assign accept   = push && (!full || pop);

  assign status_val = {{(N-9){1'b0}}, overflow, 3'b000, full, 1'b0, count};

  // I/O read mux uses pre-edge register values; non-I/O addresses contribute zero
  always_comb begin
    io_rd_val = '0;
    if (is_io) begin
      case (io_off)
        OFF_LEDS:   io_rd_val = leds;
        OFF_CYCLE:  io_rd_val = cycle_count;
        OFF_STATUS: io_rd_val = status_val;
        default:    io_rd_val = '0;
      endcase
    end
  end

  // RAM port: read-first, so a same-edge read sees the old word
  always_ff @(posedge clk) begin
    ram_q <= ram[word_idx];
    if (ram_wr) ram[word_idx] <= mem_wr_data;
  end

  // Read-side select and I/O capture; reset forces the visible read data to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram_q <= 1'b0;
      io_q      <= '0;
    end else begin
      sel_ram_q <= !is_io && in_range;
      io_q      <= io_rd_val;
    end
  end

  assign mem_rd_data = sel_ram_q ? ram_q : io_q;

  // FIFO storage needs no reset: occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= mem_wr_data[7:0];
  end

  // Control registers: LEDs, cycle counter, FIFO pointers and the two flags
  always_ff @(posedge clk) begin
    if (rst) begin
      leds         <= '0;
      cycle_count  <= '0;
      rd_ptr       <= 2'd0;
      wr_ptr       <= 2'd0;
      count        <= 3'd0;
      overflow     <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      if (io_wr && io_off == OFF_LEDS) leds <= mem_wr_data;

      if (io_wr && io_off == OFF_CYCLE) cycle_count <= mem_wr_data;
      else                              cycle_count <= cycle_count + N'(1);

      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);

      if (push && !accept)
        overflow <= 1'b1;
      else if (io_wr && io_off == OFF_STATUS && mem_wr_data[8])
        overflow <= 1'b0;

      if (fault_set) access_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_vn_memory.sv
// Testbench for mips_vn_memory: directed scenarios followed by random traffic,
// all checked against a queue/associative-array model of the memory system.
module tb_mips_vn_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [31:0] leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        access_fault;

  always #5 clk = ~clk;

  mips_vn_memory #(.N(32), .DEPTH_LOG2(10), .INIT_FILE("")) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ena   (mem_wr_ena),
    .mem_rd_data  (mem_rd_data),
    .leds         (leds),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .access_fault (access_fault)
  );

  localparam logic [31:0] A_LEDS   = 32'h8000_0000;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_leds;
  logic [31:0] m_cycle;
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [7:0]  m_fifo [$];
  bit          m_ovf;
  bit          m_fault;

  function automatic logic [31:0] model_status();
    int sz;
    sz = m_fifo.size();
    return {23'b0, m_ovf, 3'b000, (sz == 4), 1'b0, 3'(sz)};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the memory system as seen from the outside
  task automatic model_edge(input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic rdy, input logic r);
    logic [5:0] off;
    int         idx;
    int         sz;
    bit         pop, push, clr, cw, setov;
    if (r) begin
      m_rd = 32'h0; m_rd_known = 1; m_leds = 32'h0; m_cycle = 32'h0;
      m_fifo.delete(); m_ovf = 0; m_fault = 0;
      return;
    end
    off = a[7:2];
    idx = int'(a[11:2]);
    sz  = m_fifo.size();
    m_rd_known = 1;
    if (!a[31]) begin
      if (a[30:12] != 0)          m_rd = 32'h0;
      else if (m_ram.exists(idx)) m_rd = m_ram[idx];
      else begin m_rd_known = 0; m_rd = 32'h0; end
    end else if (off == 0) m_rd = m_leds;
    else if (off == 1)     m_rd = m_cycle;
    else if (off == 3)     m_rd = model_status();
    else                   m_rd = 32'h0;

    pop = (sz != 0) && rdy;
    push = 0; clr = 0; cw = 0; setov = 0;
    if (we) begin
      if (!a[31]) begin
        if (a[30:12] == 0 && a[1:0] == 0) m_ram[idx] = d;
        else m_fault = 1;
      end else if (a[1:0] != 0) m_fault = 1;
      else if (off == 0) m_leds = d;
      else if (off == 1) cw = 1;
      else if (off == 2) push = 1;
      else if (off == 3) clr = d[8];
      else m_fault = 1;
    end
    m_cycle = cw ? d : m_cycle + 32'd1;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (sz < 4 || pop) m_fifo.push_back(d[7:0]);
      else setov = 1;
    end
    if (setov) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // Drive one cycle of inputs, clock it, then compare every output against the model
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic we, input logic rdy, input logic r);
    logic [7:0] exp_head;
    mem_addr = a; mem_wr_data = d; mem_wr_ena = we; tx_ready = rdy; rst = r;
    @(posedge clk);
    #1;
    model_edge(a, d, we, rdy, r);
    exp_head = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
    if (m_rd_known) check_output("mem_rd_data", mem_rd_data, m_rd);
    check_output("leds", leds, m_leds);
    check_output("tx_valid", {31'b0, tx_valid}, {31'b0, m_fifo.size() != 0});
    check_output("tx_data", {24'b0, tx_data}, {24'b0, exp_head});
    check_output("access_fault", {31'b0, access_fault}, {31'b0, m_fault});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    apply_stimulus(a, d, 1'b1, rdy, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    apply_stimulus(a, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rdat;
    int          k;
    logic        rr;
    mem_addr = 32'h0; mem_wr_data = 32'h0; mem_wr_ena = 1'b0; tx_ready = 1'b0; rst = 1'b1;
    m_leds = 0; m_cycle = 0; m_rd = 0; m_rd_known = 0; m_ovf = 0; m_fault = 0;

    // Reset state
    apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_output("reset_rd", mem_rd_data, 32'h0);
    check_output("reset_leds", leds, 32'h0);

    // Cycle counter counts from reset: the 10th read sees 9
    for (int i = 0; i < 10; i++) rd(A_CYCLE, 1'b0);
    check_output("cycle_at_10", mem_rd_data, 32'd9);

    // RAM round trip with read-first behaviour
    wr(32'h40, 32'h1111_1111, 1'b0);
    wr(32'h40, 32'hDEAD_BEEF, 1'b0);
    check_output("read_first", mem_rd_data, 32'h1111_1111);
    rd(32'h40, 1'b0);
    check_output("ram_roundtrip", mem_rd_data, 32'hDEAD_BEEF);

    // Fault path
    wr(32'h0000_1000, 32'h1234_5678, 1'b0);
    check_output("fault_oor", {31'b0, access_fault}, 32'd1);
    wr(32'h0000_0042, 32'h0, 1'b0);
    rd(32'h0000_1000, 1'b0);
    check_output("oor_read_zero", mem_rd_data, 32'h0);
    rd(32'h40, 1'b0);
    check_output("misaligned_dropped", mem_rd_data, 32'hDEAD_BEEF);

    // Counter load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    rd(A_CYCLE, 1'b0);
    check_output("cycle_load", mem_rd_data, 32'hFFFF_FFFE);
    rd(A_CYCLE, 1'b0);
    check_output("cycle_max", mem_rd_data, 32'hFFFF_FFFF);
    rd(A_CYCLE, 1'b0);
    check_output("cycle_wrap", mem_rd_data, 32'h0);

    // FIFO fill with overflow, then drain in order
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h41 + 32'(i), 1'b0);
    rd(A_STATUS, 1'b0);
    check_output("status_full_ovf", mem_rd_data, 32'h114);
    check_output("head_first", {24'b0, tx_data}, 32'h41);
    for (int i = 0; i < 3; i++) begin
      rd(32'h40, 1'b1);
      check_output("drain_order", {24'b0, tx_data}, 32'h42 + 32'(i));
    end
    rd(32'h40, 1'b1);
    check_output("drain_empty", {31'b0, tx_valid}, 32'd0);
    wr(A_STATUS, 32'h100, 1'b0);
    rd(A_STATUS, 1'b0);
    check_output("status_cleared", mem_rd_data, 32'h0);

    // Push into a full FIFO while it pops the head
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h51 + 32'(i), 1'b0);
    wr(A_TX, 32'h55, 1'b1);
    rd(A_STATUS, 1'b0);
    check_output("status_full_no_ovf", mem_rd_data, 32'h14);
    for (int i = 0; i < 3; i++) rd(32'h40, 1'b1);
    check_output("push_pop_last", {24'b0, tx_data}, 32'h55);
    rd(32'h40, 1'b1);

    // Reset mid-stream keeps RAM but clears everything else
    for (int i = 0; i < 3; i++) wr(A_TX, 32'h61 + 32'(i), 1'b0);
    wr(A_LEDS, 32'hA5, 1'b0);
    check_output("leds_set", leds, 32'hA5);
    apply_stimulus(A_LEDS, 32'hFF, 1'b1, 1'b0, 1'b1);
    check_output("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check_output("rst_leds", leds, 32'h0);
    rd(A_STATUS, 1'b0);
    check_output("rst_status", mem_rd_data, 32'h0);
    rd(32'h40, 1'b0);
    check_output("rst_ram_kept", mem_rd_data, 32'hDEAD_BEEF);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      k    = int'($urandom_range(0, 19));
      rr   = 1'($urandom_range(0, 1));
      rdat = $urandom;
      ra   = 32'($urandom_range(0, 31)) << 2;
      if (k <= 4) wr(ra, rdat, rr);
      else if (k <= 8) rd(ra, rr);
      else if (k == 9) begin
        if ($urandom_range(0, 1) == 0) wr(32'h0000_1000 | ra, rdat, rr);
        else wr(ra | 32'($urandom_range(1, 3)), rdat, rr);
      end
      else if (k <= 11) wr(A_LEDS | (32'($urandom_range(0, 5)) << 2), rdat, rr);
      else if (k <= 13) rd(A_LEDS | (32'($urandom_range(0, 5)) << 2), rr);
      else if (k <= 16) wr(A_TX, rdat, rr);
      else if (k == 17) wr(A_LEDS | 32'($urandom_range(1, 3)), rdat, rr);
      else if (k == 18) apply_stimulus(ra, rdat, 1'($urandom_range(0, 1)), rr, 1'b1);
      else rd(A_STATUS, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
